// File: rtl/mult_rs.sv
// Multiplier reservation station: a collapsing in-order queue with CDB operand
// wakeup, oldest-ready issue to a non-stalling multiplier, and flush on mispredict.
module mult_rs #(
  parameter int ENTRIES      = 4,
  parameter int WORD_SIZE_P  = 32,
  parameter int NUM_PHYS_REG = 64,
  parameter int ROB_ENTRY    = 32,
  parameter int TAG_W        = $clog2(NUM_PHYS_REG),
  parameter int ROB_W        = $clog2(ROB_ENTRY),
  parameter int CNT_W        = $clog2(ENTRIES + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   disp_v_i,
  output logic                   disp_ready_o,
  input  logic [WORD_SIZE_P-1:0] src1_val_i,
  input  logic [WORD_SIZE_P-1:0] src2_val_i,
  input  logic [TAG_W-1:0]       src1_tag_i,
  input  logic [TAG_W-1:0]       src2_tag_i,
  input  logic                   src1_rdy_i,
  input  logic                   src2_rdy_i,
  input  logic [ROB_W-1:0]       rob_dest_i,
  input  logic [TAG_W-1:0]       reg_dest_i,
  input  logic                   cdb_v_i,
  input  logic [TAG_W-1:0]       cdb_dest_i,
  input  logic [WORD_SIZE_P-1:0] cdb_result_i,
  input  logic                   mispredict_i,
  output logic                   exe_v_o,
  output logic [WORD_SIZE_P-1:0] operand1_o,
  output logic [WORD_SIZE_P-1:0] operand2_o,
  output logic [ROB_W-1:0]       rob_dest_o,
  output logic [TAG_W-1:0]       reg_dest_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [WORD_SIZE_P-1:0] val1;
    logic [WORD_SIZE_P-1:0] val2;
    logic [TAG_W-1:0]       tag1;
    logic [TAG_W-1:0]       tag2;
    logic                   rdy1;
    logic                   rdy2;
    logic [ROB_W-1:0]       rob;
    logic [TAG_W-1:0]       rdst;
  } entry_t;

  // Ready operands are never overwritten; both operands may wake on one broadcast.
  function automatic entry_t wake_entry(input entry_t e, input logic cv,
                                        input logic [TAG_W-1:0] ct,
                                        input logic [WORD_SIZE_P-1:0] cr);
    entry_t w;
    w = e;
    w.val1 = (cv && !e.rdy1 && (e.tag1 == ct)) ? cr : e.val1;
    w.rdy1 = e.rdy1 | (cv && (e.tag1 == ct));
    w.val2 = (cv && !e.rdy2 && (e.tag2 == ct)) ? cr : e.val2;
    w.rdy2 = e.rdy2 | (cv && (e.tag2 == ct));
    return w;
  endfunction

  entry_t            slot_r   [ENTRIES];
  logic [CNT_W-1:0]  count_r;
  entry_t            wake_s   [ENTRIES+1];
  entry_t            next_s   [ENTRIES];
  entry_t            disp_raw_s;
  entry_t            disp_s;
  entry_t            sel_s;
  logic [ENTRIES-1:0] ready_s;
  logic [IDX_W-1:0]  issue_idx_s;
  logic              issue_s;
  logic              accept_s;
  logic [CNT_W-1:0]  wr_pos_s;
  logic [CNT_W-1:0]  count_next_s;

  // Oldest-ready selection: scan from the top so the lowest ready index wins.
  always_comb begin
    issue_idx_s = {IDX_W{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      ready_s[i]  = (CNT_W'(i) < count_r) && slot_r[i].rdy1 && slot_r[i].rdy2;
      issue_idx_s = ready_s[i] ? IDX_W'(i) : issue_idx_s;
    end
  end

  assign issue_s      = (|ready_s) & ~mispredict_i;
  assign sel_s        = slot_r[issue_idx_s];
  assign disp_ready_o = (count_r < CNT_W'(ENTRIES));
  assign accept_s     = disp_v_i & disp_ready_o & ~mispredict_i;
  assign wr_pos_s     = count_r - CNT_W'(issue_s);

  assign exe_v_o    = issue_s;
  assign operand1_o = issue_s ? sel_s.val1 : {WORD_SIZE_P{1'b0}};
  assign operand2_o = issue_s ? sel_s.val2 : {WORD_SIZE_P{1'b0}};
  assign rob_dest_o = issue_s ? sel_s.rob  : {ROB_W{1'b0}};
  assign reg_dest_o = issue_s ? sel_s.rdst : {TAG_W{1'b0}};
  assign count_o    = count_r;

  // Next-state: wake every slot, collapse over the issued slot, append dispatch.
  always_comb begin
    disp_raw_s.val1 = src1_val_i;
    disp_raw_s.val2 = src2_val_i;
    disp_raw_s.tag1 = src1_tag_i;
    disp_raw_s.tag2 = src2_tag_i;
    disp_raw_s.rdy1 = src1_rdy_i;
    disp_raw_s.rdy2 = src2_rdy_i;
    disp_raw_s.rob  = rob_dest_i;
    disp_raw_s.rdst = reg_dest_i;
    disp_s = wake_entry(disp_raw_s, cdb_v_i, cdb_dest_i, cdb_result_i);
    wake_s[ENTRIES] = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wake_s[i] = wake_entry(slot_r[i], cdb_v_i, cdb_dest_i, cdb_result_i);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      next_s[i] = (issue_s && (IDX_W'(i) >= issue_idx_s)) ? wake_s[i+1] : wake_s[i];
      next_s[i] = (accept_s && (CNT_W'(i) == wr_pos_s)) ? disp_s : next_s[i];
    end
    if (mispredict_i) begin
      count_next_s = {CNT_W{1'b0}};
    end else begin
      count_next_s = count_r + CNT_W'(accept_s) - CNT_W'(issue_s);
    end
  end

  // Slot storage and occupancy register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < ENTRIES; i++) slot_r[i] <= '0;
    end else begin
      count_r <= count_next_s;
      for (int i = 0; i < ENTRIES; i++) slot_r[i] <= next_s[i];
    end
  end

endmodule

// File: tb/tb_mult_rs.sv
// Self-checking bench for mult_rs: a queue-based reference model compared every
// cycle, plus directed scenarios pinned with hand-computed values.
module tb_mult_rs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_v_i, disp_ready_o;
  logic [31:0] src1_val_i, src2_val_i;
  logic [5:0]  src1_tag_i, src2_tag_i;
  logic        src1_rdy_i, src2_rdy_i;
  logic [4:0]  rob_dest_i;
  logic [5:0]  reg_dest_i;
  logic        cdb_v_i;
  logic [5:0]  cdb_dest_i;
  logic [31:0] cdb_result_i;
  logic        mispredict_i;
  logic        exe_v_o;
  logic [31:0] operand1_o, operand2_o;
  logic [4:0]  rob_dest_o;
  logic [5:0]  reg_dest_o;
  logic [2:0]  count_o;

  int n_pass = 0;
  int n_total = 0;

  mult_rs dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .disp_v_i(disp_v_i), .disp_ready_o(disp_ready_o),
    .src1_val_i(src1_val_i), .src2_val_i(src2_val_i),
    .src1_tag_i(src1_tag_i), .src2_tag_i(src2_tag_i),
    .src1_rdy_i(src1_rdy_i), .src2_rdy_i(src2_rdy_i),
    .rob_dest_i(rob_dest_i), .reg_dest_i(reg_dest_i),
    .cdb_v_i(cdb_v_i), .cdb_dest_i(cdb_dest_i), .cdb_result_i(cdb_result_i),
    .mispredict_i(mispredict_i),
    .exe_v_o(exe_v_o), .operand1_o(operand1_o), .operand2_o(operand2_o),
    .rob_dest_o(rob_dest_o), .reg_dest_o(reg_dest_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v1, v2;
    logic [5:0]  t1, t2;
    logic        r1, r2;
    logic [4:0]  rob;
    logic [5:0]  rg;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int first_ready();
    for (int i = 0; i < q.size(); i++) if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  // Reference: oldest ready leaves, waiting operands catch matching broadcasts,
  // dispatch joins the tail if the queue had room before this cycle's issue.
  task automatic model_step();
    int   n0, ir;
    ent_t d;
    n0 = q.size();
    ir = first_ready();
    if (mispredict_i) begin
      q.delete();
      return;
    end
    if (ir >= 0) q.delete(ir);
    foreach (q[i]) begin
      if (cdb_v_i && !q[i].r1 && q[i].t1 == cdb_dest_i) begin q[i].v1 = cdb_result_i; q[i].r1 = 1'b1; end
      if (cdb_v_i && !q[i].r2 && q[i].t2 == cdb_dest_i) begin q[i].v2 = cdb_result_i; q[i].r2 = 1'b1; end
    end
    if (disp_v_i && n0 < 4) begin
      d.v1 = src1_val_i; d.v2 = src2_val_i; d.t1 = src1_tag_i; d.t2 = src2_tag_i;
      d.r1 = src1_rdy_i; d.r2 = src2_rdy_i; d.rob = rob_dest_i; d.rg = reg_dest_i;
      if (cdb_v_i && !d.r1 && d.t1 == cdb_dest_i) begin d.v1 = cdb_result_i; d.r1 = 1'b1; end
      if (cdb_v_i && !d.r2 && d.t2 == cdb_dest_i) begin d.v2 = cdb_result_i; d.r2 = 1'b1; end
      q.push_back(d);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) q.delete();
    else model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int   ci;
    logic ev;
    ci = first_ready();
    ev = (ci >= 0) && !mispredict_i;
    chk("exe_v", exe_v_o, ev);
    chk("count", count_o, q.size());
    chk("disp_ready", disp_ready_o, q.size() < 4);
    if (ev) begin
      chk("operand1", operand1_o, q[ci].v1);
      chk("operand2", operand2_o, q[ci].v2);
      chk("rob_dest", rob_dest_o, q[ci].rob);
      chk("reg_dest", reg_dest_o, q[ci].rg);
    end else begin
      chk("idle_data", {operand1_o, operand2_o[20:0], rob_dest_o, reg_dest_o}, 64'd0);
    end
  end

  task automatic idle_inputs();
    disp_v_i = 1'b0; src1_val_i = 32'd0; src2_val_i = 32'd0;
    src1_tag_i = 6'd0; src2_tag_i = 6'd0; src1_rdy_i = 1'b0; src2_rdy_i = 1'b0;
    rob_dest_i = 5'd0; reg_dest_i = 6'd0;
    cdb_v_i = 1'b0; cdb_dest_i = 6'd0; cdb_result_i = 32'd0; mispredict_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic disp(input logic [31:0] a, input logic [5:0] ta, input logic ra,
                      input logic [31:0] b, input logic [5:0] tb2, input logic rb,
                      input logic [4:0] rob, input logic [5:0] rg);
    disp_v_i = 1'b1; src1_val_i = a; src1_tag_i = ta; src1_rdy_i = ra;
    src2_val_i = b; src2_tag_i = tb2; src2_rdy_i = rb;
    rob_dest_i = rob; reg_dest_i = rg;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] v);
    cdb_v_i = 1'b1; cdb_dest_i = t; cdb_result_i = v;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    at_neg();
    chk("rst_exe_v", exe_v_o, 1'b0);
    chk("rst_count", count_o, 3'd0);
    chk("rst_disp_ready", disp_ready_o, 1'b1);
    chk("rst_operand1", operand1_o, 32'd0);

    // Single ready dispatch issues one cycle later.
    tick(); reset_n = 1'b1;
    disp(32'd3, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 5'd1, 6'd1);
    at_neg(); chk("d1_count0", count_o, 3'd0);
    tick(); at_neg();
    chk("d1_exe_v", exe_v_o, 1'b1);
    chk("d1_op1", operand1_o, 32'd3);
    chk("d1_op2", operand2_o, 32'd5);
    tick(); at_neg(); chk("d1_count_back", count_o, 3'd0);

    // Fill with src2 waiting on tag 7, then one broadcast releases all four.
    for (int k = 0; k < 4; k++) begin
      tick(); disp(32'(k + 1), 6'd0, 1'b1, 32'd0, 6'd7, 1'b0, 5'(k), 6'(k)); at_neg();
    end
    tick(); cdb(6'd7, 32'd9); at_neg();
    chk("d2_full_ready", disp_ready_o, 1'b0);
    chk("d2_full_count", count_o, 3'd4);
    for (int k = 0; k < 4; k++) begin
      tick(); at_neg();
      chk("d2_exe_v", exe_v_o, 1'b1);
      chk("d2_op1", operand1_o, 32'(k + 1));
      chk("d2_op2", operand2_o, 32'd9);
    end

    // Younger ready entry bypasses an older waiting one.
    tick(); disp(32'd0, 6'd2, 1'b0, 32'd1, 6'd0, 1'b1, 5'd10, 6'd1); at_neg();
    tick(); disp(32'd7, 6'd0, 1'b1, 32'd8, 6'd0, 1'b1, 5'd11, 6'd2); at_neg();
    tick(); at_neg();
    chk("d3_rob_first", rob_dest_o, 5'd11);
    tick(); cdb(6'd2, 32'd6); at_neg();
    chk("d3_wait_exe_v", exe_v_o, 1'b0);
    tick(); at_neg();
    chk("d3_rob_second", rob_dest_o, 5'd10);
    chk("d3_op1_woken", operand1_o, 32'd6);

    // Dispatch bypass from a same-cycle broadcast.
    tick(); disp(32'd0, 6'd4, 1'b0, 32'd2, 6'd0, 1'b1, 5'd3, 6'd3); cdb(6'd4, 32'd11); at_neg();
    tick(); at_neg();
    chk("d4_exe_v", exe_v_o, 1'b1);
    chk("d4_op1_bypass", operand1_o, 32'd11);

    // Full queue: dispatch with a same-cycle issue is still rejected.
    for (int k = 0; k < 4; k++) begin
      tick(); disp(32'd0, 6'd9, 1'b0, 32'(k + 20), 6'd0, 1'b1, 5'(k + 4), 6'(k)); at_neg();
    end
    tick(); cdb(6'd9, 32'd5); at_neg();
    tick(); disp(32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 5'd30, 6'd30); at_neg();
    chk("d5_reject_ready", disp_ready_o, 1'b0);
    chk("d5_rob", rob_dest_o, 5'd4);
    tick(); at_neg();
    chk("d5_count3", count_o, 3'd3);
    tick(); tick(); tick(); at_neg();
    chk("d5_drained", count_o, 3'd0);

    // Mispredict flushes everything including the same-cycle dispatch.
    tick(); disp(32'd0, 6'd12, 1'b0, 32'd1, 6'd0, 1'b1, 5'd1, 6'd1); at_neg();
    tick(); disp(32'd0, 6'd12, 1'b0, 32'd1, 6'd0, 1'b1, 5'd2, 6'd2); at_neg();
    tick(); disp(32'd5, 6'd0, 1'b1, 32'd6, 6'd0, 1'b1, 5'd3, 6'd3); at_neg();
    tick(); mispredict_i = 1'b1; disp(32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 5'd9, 6'd9); at_neg();
    chk("d6_exe_v_forced", exe_v_o, 1'b0);
    tick(); at_neg();
    chk("d6_count0", count_o, 3'd0);
    tick(); cdb(6'd12, 32'd4); at_neg();
    tick(); at_neg();
    chk("d6_no_issue", exe_v_o, 1'b0);

    // Reset mid-operation discards the stored entry.
    tick(); disp(32'd2, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 5'd1, 6'd1); at_neg();
    tick(); reset_n = 1'b0; at_neg();
    chk("d7_rst_count", count_o, 3'd0);
    chk("d7_rst_exe_v", exe_v_o, 1'b0);
    tick(); reset_n = 1'b1; at_neg();
    tick(); at_neg();
    chk("d7_post_exe_v", exe_v_o, 1'b0);

    // Randomized traffic with narrow tag space to force frequent matches.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) < 6)
        disp($urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
      if ($urandom_range(0, 9) < 4) cdb(6'($urandom_range(0, 7)), $urandom);
      mispredict_i = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
    end
    tick(); reset_n = 1'b1; mispredict_i = 1'b1;
    tick(); at_neg();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_rs.md
MULT_RS -- requirements
Module: mult_rs

Interface
Parameters:
REQ-001 ENTRIES, 4, number of reservation-station slots (≥2).
REQ-002 WORD_SIZE_P, package value, operand/result width.
REQ-003 TAG_W, $clog2(NUM_PHYS_REG), physical-register tag width.
REQ-004 ROB_W, $clog2(ROB_ENTRY), ROB index width.

Ports:
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 disp_v_i  in  1  dispatch request.
REQ-008 disp_ready_o  out  1  slot free; dispatch accepted when disp_v_i && disp_ready_o.
REQ-009 src1_val_i, src2_val_i  in  WORD_SIZE_P each  operand values.
REQ-010 src1_tag_i, src2_tag_i  in  TAG_W each  producer tags.
REQ-011 src1_rdy_i, src2_rdy_i  in  1 each  operand value already valid.
REQ-012 rob_dest_i  in  ROB_W  ROB index of instruction.
REQ-013 reg_dest_i  in  TAG_W  destination physical register.
REQ-014 cdb_v_i  in  1  CDB broadcast valid.
REQ-015 cdb_dest_i  in  TAG_W  broadcast tag.
REQ-016 cdb_result_i  in  WORD_SIZE_P  broadcast value.
REQ-017 mispredict_i  in  1  flush all state.
REQ-018 exe_v_o  out  1  issue valid to multiplier.
REQ-019 operand1_o, operand2_o  out  WORD_SIZE_P each  issued operands.
REQ-020 rob_dest_o  out  ROB_W  issued ROB index.
REQ-021 reg_dest_o  out  TAG_W  issued destination.
REQ-022 count_o  out  $clog2(ENTRIES+1)  occupied slots.

Function
REQ-023 Storage is a collapsing queue; slot 0 oldest; slots 0..count-1 valid, contiguous.
REQ-024 Entry ready when both operand rdy bits set.
REQ-025 Issue combinational from state: exe_v_o=1 iff any valid entry ready; selects lowest-index ready entry; outputs carry its fields.
REQ-026 Multiplier never stalls; issued entry removed at the same edge; younger entries shift down one slot.
REQ-027 When exe_v_o=0, operand/dest outputs are don't-care but shall hold 0.
REQ-028 disp_ready_o = (count < ENTRIES); same-cycle issue does not count as a free slot.
REQ-029 Accepted dispatch written at slot count (count-1 if an issue occurs same edge); eligible for issue the following cycle (minimum dispatch-to-exe_v_o latency 1 cycle).
REQ-030 Wakeup: each valid, not-ready operand whose tag equals cdb_dest_i when cdb_v_i=1 captures cdb_result_i and sets rdy at the edge; entry issuable next cycle.
REQ-031 Dispatch bypass: operand dispatched not-ready whose tag matches a same-cycle CDB broadcast is written ready with cdb_result_i.
REQ-032 Both operands of one entry may wake on the same broadcast.
REQ-033 count_o updates +1 dispatch, −1 issue, unchanged for both/neither; never exceeds ENTRIES nor underflows.
REQ-034 mispredict_i=1: exe_v_o forced 0 that cycle; at the edge all entries invalidated, count=0; same-cycle dispatch discarded.
REQ-035 CDB broadcasts with no matching tag have no effect; already-ready operands never overwritten.

Reset
REQ-036 reset_n_i low asynchronously clears all valid/rdy bits and count; exe_v_o=0, count_o=0, disp_ready_o=1, data outputs 0, held while low.
REQ-037 Reset asserted mid-operation discards all entries; no issue occurs in the first cycle after release unless a dispatch was accepted at that edge.

Verification
REQ-038 Dispatch ready entry (3,5) at cycle 0 -> cycle 1 exe_v_o=1, operand1_o=3, operand2_o=5, count_o returns 0 at cycle 2.
REQ-039 Fill 4 entries with src2 waiting on tag 7 -> disp_ready_o=0; cdb tag 7 value 9 -> four consecutive issues in dispatch order, operand2_o=9.
REQ-040 Entry 0 waiting, entry 1 ready -> entry 1 issues first; entry 0 shifts to slot 0; order preserved.
REQ-041 Dispatch src1 tag 4 not-ready in same cycle as cdb tag 4 value 11 -> next cycle issue with operand1_o=11.
REQ-042 Full queue, dispatch plus issue same cycle -> dispatch rejected (disp_ready_o=0), count drops to 3.
REQ-043 mispredict_i with 3 entries, one ready, plus a dispatch -> exe_v_o=0 that cycle, count_o=0 next cycle, no later issue.
